// File: rtl/smm_pkg.sv
// Shared types and constants for the SMM multiply-accumulate datapath.
package smm_pkg;
  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic signed_any;
  } flag_t;

  function automatic int PROD_WIDTH(input int d0, input int d1);
    return d0 + d1;
  endfunction
endpackage

// File: rtl/smm_mac_pipe_if.sv
// Beat/result bus between SMM operand fetch, the MAC pipe and the output stage.
interface smm_mac_pipe_if #(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 32,
  parameter int ACC_WIDTH  = 64
);
  logic                             ce;
  logic                             in_valid;
  logic                             in_signed0;
  logic                             in_signed1;
  logic                             in_first;
  logic                             in_last;
  logic [DIN0_WIDTH-1:0]            din0;
  logic [DIN1_WIDTH-1:0]            din1;
  logic                             prod_valid;
  logic [DIN0_WIDTH+DIN1_WIDTH-1:0] prod;
  logic                             acc_valid;
  logic [ACC_WIDTH-1:0]             acc_out;
  logic                             acc_ovf;

  modport master (
    output ce, in_valid, in_signed0, in_signed1, in_first, in_last, din0, din1,
    input  prod_valid, prod, acc_valid, acc_out, acc_ovf
  );
  modport slave (
    input  ce, in_valid, in_signed0, in_signed1, in_first, in_last, din0, din1,
    output prod_valid, prod, acc_valid, acc_out, acc_ovf
  );
endinterface

// File: rtl/smm_mul_pipe.sv
// Operand extension and signed multiply in an NS-deep pipeline that carries the beat flags.
module smm_mul_pipe import smm_pkg::*; #(
  parameter int D0 = 32,
  parameter int D1 = 32,
  parameter int NS = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  input  flag_t          i_flg,
  input  logic           i_sgn0,
  input  logic           i_sgn1,
  input  logic [D0-1:0]  i_din0,
  input  logic [D1-1:0]  i_din1,
  output flag_t          o_flg,
  output logic [D0+D1-1:0] o_prod
);
  localparam int PW = PROD_WIDTH(D0, D1);

  logic [D0:0] w_ext0;
  logic [D1:0] w_ext1;
  assign w_ext0 = {i_sgn0 & i_din0[D0-1], i_din0};
  assign w_ext1 = {i_sgn1 & i_din1[D1-1], i_din1};

  flag_t r_flg [NS:1];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 1; s <= NS; s++) r_flg[s] <= '0;
    end else if (ce) begin
      r_flg[1] <= i_flg;
      for (int s = 2; s <= NS; s++) r_flg[s] <= r_flg[s-1];
    end
  end
  assign o_flg = r_flg[NS];

  // Both extended operands are widened to PW; the low PW bits of the product are exact.
  generate
    if (NS == 1) begin : g_ns1
      logic [PW-1:0] w_mul;
      logic [PW-1:0] r_prod;
      assign w_mul = {{(D1-1){w_ext0[D0]}}, w_ext0} * {{(D0-1){w_ext1[D1]}}, w_ext1};
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)  r_prod <= '0;
        else if (ce) r_prod <= w_mul;
      end
      assign o_prod = r_prod;
    end else begin : g_nsn
      logic [D0:0]   r_op0;
      logic [D1:0]   r_op1;
      logic [PW-1:0] w_mul;
      logic [PW-1:0] r_prod [NS:2];
      assign w_mul = {{(D1-1){r_op0[D0]}}, r_op0} * {{(D0-1){r_op1[D1]}}, r_op1};
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_op0 <= '0;
          r_op1 <= '0;
          for (int s = 2; s <= NS; s++) r_prod[s] <= '0;
        end else if (ce) begin
          r_op0    <= w_ext0;
          r_op1    <= w_ext1;
          r_prod[2] <= w_mul;
          for (int s = 3; s <= NS; s++) r_prod[s] <= r_prod[s-1];
        end
      end
      assign o_prod = r_prod[NS];
    end
  endgenerate
endmodule

// File: rtl/smm_mac_pipe.sv
// Pipelined signed/unsigned multiplier with a first/last framed accumulator and sticky overflow.
module smm_mac_pipe import smm_pkg::*; #(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 32,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_WIDTH  = 64
) (
  input  logic          clk,
  input  logic          reset,
  smm_mac_pipe_if.slave bus
);
  localparam int PW = PROD_WIDTH(DIN0_WIDTH, DIN1_WIDTH);

  generate
    if (ACC_WIDTH < PW) begin : g_bad_acc
      $error("smm_mac_pipe: ACC_WIDTH must be >= DIN0_WIDTH+DIN1_WIDTH");
    end
    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_ns
      $error("smm_mac_pipe: NUM_STAGE out of range");
    end
  endgenerate

  flag_t         w_flg_in, w_flg;
  logic [PW-1:0] w_prod;

  assign w_flg_in = {bus.in_valid, bus.in_first, bus.in_last, bus.in_signed0 | bus.in_signed1};

  smm_mul_pipe #(.D0(DIN0_WIDTH), .D1(DIN1_WIDTH), .NS(NUM_STAGE)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .ce     (bus.ce),
    .i_flg  (w_flg_in),
    .i_sgn0 (bus.in_signed0),
    .i_sgn1 (bus.in_signed1),
    .i_din0 (bus.din0),
    .i_din1 (bus.din1),
    .o_flg  (w_flg),
    .o_prod (w_prod)
  );

  logic [ACC_WIDTH-1:0] r_acc, r_acc_out, w_add, w_base, w_sum;
  logic                 r_trk, r_acc_valid, r_acc_ovf, w_carry, w_beat_ovf, w_trk;

  // A first beat starts from zero, so it can never flag overflow itself.
  always_comb begin
    if (w_flg.signed_any) w_add = ACC_WIDTH'($signed(w_prod));
    else                  w_add = ACC_WIDTH'(w_prod);
    w_base = w_flg.first ? '0 : r_acc;
    {w_carry, w_sum} = {1'b0, w_base} + {1'b0, w_add};
    if (w_flg.signed_any)
      w_beat_ovf = (w_base[ACC_WIDTH-1] == w_add[ACC_WIDTH-1]) &&
                   (w_sum[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]);
    else
      w_beat_ovf = w_carry;
    w_trk = (w_flg.first ? 1'b0 : r_trk) | w_beat_ovf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_trk       <= 1'b0;
      r_acc_out   <= '0;
      r_acc_ovf   <= 1'b0;
      r_acc_valid <= 1'b0;
    end else if (bus.ce) begin
      r_acc_valid <= w_flg.valid & w_flg.last;
      if (w_flg.valid) begin
        r_acc <= w_sum;
        r_trk <= w_trk;
        if (w_flg.last) begin
          r_acc_out <= w_sum;
          r_acc_ovf <= w_trk;
        end
      end
    end
  end

  assign bus.prod_valid = w_flg.valid;
  assign bus.prod       = w_prod;
  assign bus.acc_valid  = r_acc_valid;
  assign bus.acc_out    = r_acc_out;
  assign bus.acc_ovf    = r_acc_ovf;
endmodule

// File: doc/smm_mac_pipe.md
Name: smm_mac_pipe

Overview:
Parametrised pipelined multiplier with integrated accumulator, the successor of the fixed 2-stage unsigned multiplier used by the SMM matrix-multiply datapath of the LeNet-5 accelerator. It adds configurable depth, per-beat signed/unsigned operand mode, and valid tracking through the pipeline. It also accumulates dot-product beats framed by first/last flags, with a sticky overflow flag. It sits between the SMM operand fetch and the output/bias stage.

Parameters:
DIN0_WIDTH, 32, width of operand 0 (range 2..32)
DIN1_WIDTH, 32, width of operand 1 (range 2..32)
NUM_STAGE, 2, product pipeline depth in ce-qualified cycles (range 1..4)
ACC_WIDTH, 64, accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH (elaboration error otherwise)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous reset, active-low
ce  in  1  pipeline advance enable; 0 freezes every register (data, valid, flags, acc)
in_valid  in  1  input beat valid
in_signed0  in  1  1: din0 is two's complement; 0: unsigned
in_signed1  in  1  1: din1 is two's complement; 0: unsigned
in_first  in  1  beat opens a new accumulation
in_last  in  1  beat closes the accumulation
din0  in  DIN0_WIDTH  operand 0
din1  in  DIN1_WIDTH  operand 1
prod_valid  out  1  prod holds a valid product
prod  out  DIN0_WIDTH+DIN1_WIDTH  product
acc_valid  out  1  one-cycle pulse: acc_out holds a completed sum
acc_out  out  ACC_WIDTH  completed accumulation
acc_ovf  out  1  overflow occurred within the sum reported by acc_out

Behaviour:
- Reset (async assert, sync deassert external): every valid, flag, data register, acc, prod, acc_out, acc_valid and acc_ovf clears to 0 immediately. Reset mid-accumulation discards the partial sum.
- Operand extension: each operand is extended by 1 bit (sign bit if in_signedX, else 0). Product = signed(ext0)*signed(ext1), truncated to DIN0_WIDTH+DIN1_WIDTH bits. The truncation is exact for all mode mixes.
- Product pipeline: stage 1 registers the extended operands plus valid/first/last/signed-any flags. Stages 2..NUM_STAGE register the product. For NUM_STAGE=1, the multiply sits between the inputs and a single product register.
- Latency: prod/prod_valid appear NUM_STAGE ce-high edges after the input edge. acc_out/acc_valid appear one ce-high edge later (NUM_STAGE+1).
- Throughput: one beat per ce-high cycle; no backpressure. in_valid=0 inserts a bubble that travels with valid=0. Bubbles never modify acc.
- Accumulator: on a valid product at the pipeline output, addend = product extended to ACC_WIDTH (sign-extended if either operand signed, else zero-extended).
  - first=1: acc <= addend and the overflow tracker clears.
  - first=0: acc <= acc + addend, modulo 2^ACC_WIDTH.
- Overflow: for a signed beat, flag signed overflow (operand signs equal, result sign differs). For an unsigned beat, flag carry-out. The tracker is sticky until the next first.
- Completion: a valid beat with last=1 loads acc_out with the updated sum and acc_ovf with the updated tracker, and pulses acc_valid for one ce-high cycle. acc_valid drops on the next ce-high edge. acc_out and acc_ovf hold until the next completion.
- first=1 and last=1 together: a single-beat sum; acc_out = extended product.
- A beat with first=0 after reset or after a completed sum adds onto the current acc (0 after reset; the previous sum's value after last). The producer must assert first; the block does not guard this.
- first=1 while a sum is open: the partial sum is silently discarded with no acc_valid.
- ce=0: all state holds, including an asserted acc_valid (it remains high until the next ce-high edge).

Decomposition:
- Shared package smm_pkg: PROD_WIDTH function (DIN0+DIN1), a flag-bundle typedef (valid, first, last, signed_any), and the NUM_STAGE legal-range constants.
- One sub-module, smm_mul_pipe: operand extension, multiply and NUM_STAGE pipeline carrying the flag bundle.
- smm_mac_pipe instantiates it and adds the accumulator/overflow/output stage.

Test Plan:
1. NUM_STAGE=2, unsigned, din0=0xFFFFFFFF, din1=0xFFFFFFFF, first=last=1 -> prod=0xFFFFFFFE00000001 at edge 2, acc_out identical and acc_valid pulse at edge 3, acc_ovf=0.
2. Signed mixes, NUM_STAGE=1, 8x8 widths, ACC_WIDTH=16: (-3)x(5) signed/signed -> prod=0xFFF1. Unsigned 0xFD x signed 5 -> prod=0x04F1. 4-beat sum of products 2,-3,7,1 (first on beat 0, last on beat 3) -> acc_out=7.
3. Bubbles and ce: 3-beat sum with in_valid=0 gaps and ce held low 2 cycles mid-stream -> same acc_out as gap-free run; latency extended by exactly the frozen cycles; acc_valid held high while ce=0.
4. Overflow: ACC_WIDTH=16, unsigned 8x8, four beats of 0xFF*0xFF (0xFE01) -> acc_out=0xF804, acc_ovf=1. The next single-beat sum 1x1 -> acc_out=1, acc_ovf=0.
5. Restart: first on beat 0 (value 10), first again on beat 2 (value 4), last on beat 3 (value 6) -> exactly one acc_valid, acc_out=10.
6. Reset: assert reset with 2 valid beats in flight -> all outputs 0 immediately, no acc_valid after release. A new first/last beat 3x4 -> acc_out=12.
